// File: rtl/mem_access_ctrl_pkg.sv
// Shared state encoding and default sizing for the memory-stage access controller.
package mem_access_ctrl_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   localparam int DATA_W_DEF  = 16;
   localparam int TIMEOUT_DEF = 15;
   localparam int CNT_W_DEF   = 4;

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// Wait-cycle counter: clear, increment-enable and terminal count at TIMEOUT.
module mem_wait_counter
   import mem_access_ctrl_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues word loads/stores to a multi-cycle
// data memory, stalls the pipeline until completion or timeout, feeds MEM/WB.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memRead_XM,
   input  logic              memWrite_XM,
   input  logic              HALT_XM,
   input  logic [DATA_W-1:0] addr_XM,
   input  logic [DATA_W-1:0] wdata_XM,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_done,
   input  logic              mem_err,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              stall_mem,
   output logic [DATA_W-1:0] readFromMem,
   output logic              data_en,
   output logic              err_data
);

   state_e            state_q;
   state_e            state_d;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;
   logic              acc;
   logic              illegal;
   logic              cnt_clr;
   logic              cnt_inc;
   logic              cnt_tc;

   assign acc     = (memRead_XM | memWrite_XM) & ~HALT_XM;
   assign illegal = acc & (addr_XM[0] | (memRead_XM & memWrite_XM));

   mem_wait_counter #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) u_wait_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (cnt_inc),
      .tc  (cnt_tc)
   );

   // All outputs are held low while reset is asserted, independent of inputs.
   always_comb begin
      state_d   = state_q;
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      stall_mem = 1'b0;
      data_en   = 1'b0;
      err_data  = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      if (rst) begin
         case (state_q)
            ST_IDLE: begin
               if (illegal) begin
                  err_data = 1'b1;
               end else if (acc) begin
                  mem_en    = 1'b1;
                  mem_wr    = memWrite_XM;
                  mem_addr  = addr_XM;
                  mem_wdata = wdata_XM;
                  if (mem_done) begin
                     data_en  = memRead_XM;
                     err_data = mem_err;
                  end else begin
                     stall_mem = 1'b1;
                     cnt_clr   = 1'b1;
                     state_d   = ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               // Completion wins over timeout when both land in the same cycle.
               if (mem_done) begin
                  data_en  = memRead_XM;
                  err_data = mem_err;
                  state_d  = ST_IDLE;
               end else if (cnt_tc) begin
                  err_data = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  stall_mem = 1'b1;
                  cnt_inc   = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      rdata_d = data_en ? mem_rdata : rdata_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
      end
   end

   assign readFromMem = data_en ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized transactions
// checked against a transaction-level model of stall/data/error timing.
module tb_mem_access_ctrl;
   import mem_access_ctrl_pkg::*;

   localparam int DW = 16;
   localparam int TO = 15;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          memRead_XM;
   logic          memWrite_XM;
   logic          HALT_XM;
   logic          mem_done;
   logic          mem_err;
   logic [DW-1:0] addr_XM;
   logic [DW-1:0] wdata_XM;
   logic [DW-1:0] mem_rdata;
   logic          mem_en;
   logic          mem_wr;
   logic          stall_mem;
   logic          data_en;
   logic          err_data;
   logic [DW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] readFromMem;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [DW-1:0] exp_rdata = '0;

   wire [3:0] ctl = {mem_en, stall_mem, data_en, err_data};

   always #5 clk = ~clk;

   mem_access_ctrl #(
      .DATA_W  (DW),
      .TIMEOUT (TO),
      .CNT_W   (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .memRead_XM  (memRead_XM),
      .memWrite_XM (memWrite_XM),
      .HALT_XM     (HALT_XM),
      .addr_XM     (addr_XM),
      .wdata_XM    (wdata_XM),
      .mem_rdata   (mem_rdata),
      .mem_done    (mem_done),
      .mem_err     (mem_err),
      .mem_en      (mem_en),
      .mem_wr      (mem_wr),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .stall_mem   (stall_mem),
      .readFromMem (readFromMem),
      .data_en     (data_en),
      .err_data    (err_data)
   );

   task automatic set_idle();
      memRead_XM  = 1'b0;
      memWrite_XM = 1'b0;
      HALT_XM     = 1'b0;
      mem_done    = 1'b0;
      mem_err     = 1'b0;
      addr_XM     = '0;
      wdata_XM    = '0;
      mem_rdata   = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_idle();
      #1;
      rst = 1'b0;
      memRead_XM = 1'b1;
      mem_done   = 1'b1;
      addr_XM    = 16'h0010;
      mem_rdata  = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
         #2;
         n_cmp++;
         if (ctl !== 4'b0000 || readFromMem !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_hold: ctl=%b rfm=%h, expected ctl=0000 rfm=0000", ctl, readFromMem);
         end
         tick();
      end
      set_idle();
      rst = 1'b1;
      exp_rdata = '0;
      #2;
      n_cmp++;
      if (ctl !== 4'b0000 || readFromMem !== 16'h0000) begin
         n_bad++;
         $display("FAIL reset_release: ctl=%b rfm=%h, expected ctl=0000 rfm=0000", ctl, readFromMem);
      end
      tick();
   endtask

   task automatic test_hit_load();
      set_idle();
      memRead_XM = 1'b1;
      addr_XM    = 16'h0010;
      mem_done   = 1'b1;
      mem_rdata  = 16'hBEEF;
      #2;
      n_cmp++;
      if (ctl !== 4'b1010 || readFromMem !== 16'hBEEF || mem_wr !== 1'b0 || mem_addr !== 16'h0010) begin
         n_bad++;
         $display("FAIL hit_load: ctl=%b rfm=%h wr=%b addr=%h, expected ctl=1010 rfm=beef wr=0 addr=0010",
                  ctl, readFromMem, mem_wr, mem_addr);
      end
      exp_rdata = 16'hBEEF;
      tick();
      set_idle();
      mem_rdata = 16'h5555;
      #2;
      n_cmp++;
      if (ctl !== 4'b0000 || readFromMem !== 16'hBEEF) begin
         n_bad++;
         $display("FAIL hit_load_hold: ctl=%b rfm=%h, expected ctl=0000 rfm=beef", ctl, readFromMem);
      end
      tick();
   endtask

   task automatic test_miss_store();
      int         n_en;
      logic [3:0] exp_ctl;
      n_en = 0;
      set_idle();
      memWrite_XM = 1'b1;
      addr_XM     = 16'h0200;
      wdata_XM    = 16'h1234;
      for (int c = 0; c < 4; c++) begin
         mem_done  = (c == 3);
         mem_rdata = 16'($urandom);
         #2;
         if (mem_en === 1'b1) n_en++;
         exp_ctl = {(c == 0), (c < 3), 1'b0, 1'b0};
         n_cmp++;
         if (ctl !== exp_ctl || readFromMem !== exp_rdata) begin
            n_bad++;
            $display("FAIL miss_store c%0d: ctl=%b rfm=%h, expected ctl=%b rfm=%h",
                     c, ctl, readFromMem, exp_ctl, exp_rdata);
         end
         if (c == 0) begin
            n_cmp++;
            if (mem_wr !== 1'b1 || mem_addr !== 16'h0200 || mem_wdata !== 16'h1234) begin
               n_bad++;
               $display("FAIL miss_store_req: wr=%b addr=%h wdata=%h, expected wr=1 addr=0200 wdata=1234",
                        mem_wr, mem_addr, mem_wdata);
            end
         end
         tick();
      end
      n_cmp++;
      if (n_en != 1) begin
         n_bad++;
         $display("FAIL miss_store_pulses: mem_en pulses=%0d, expected 1", n_en);
      end
   endtask

   task automatic test_illegal();
      for (int k = 0; k < 2; k++) begin
         set_idle();
         memRead_XM  = 1'b1;
         memWrite_XM = (k == 1);
         addr_XM     = (k == 0) ? 16'h0011 : 16'h0010;
         mem_done    = 1'b1;
         mem_rdata   = 16'hDEAD;
         #2;
         n_cmp++;
         if (ctl !== 4'b0001 || readFromMem !== exp_rdata) begin
            n_bad++;
            $display("FAIL illegal_%0d: ctl=%b rfm=%h, expected ctl=0001 rfm=%h",
                     k, ctl, readFromMem, exp_rdata);
         end
         tick();
      end
   endtask

   task automatic test_timeout();
      int stalls;
      bit seen;
      stalls = 0;
      seen   = 1'b0;
      set_idle();
      memRead_XM = 1'b1;
      addr_XM    = 16'h0040;
      for (int c = 0; c < 40 && !seen; c++) begin
         mem_rdata = 16'($urandom);
         #2;
         if (stall_mem === 1'b1) begin
            stalls++;
         end else begin
            seen = 1'b1;
            n_cmp++;
            if (ctl !== 4'b0001 || readFromMem !== exp_rdata) begin
               n_bad++;
               $display("FAIL timeout_end: ctl=%b rfm=%h, expected ctl=0001 rfm=%h",
                        ctl, readFromMem, exp_rdata);
            end
         end
         tick();
      end
      n_cmp++;
      if (!seen || stalls != TO + 1) begin
         n_bad++;
         $display("FAIL timeout_stalls: stalls=%0d ended=%0d, expected stalls=%0d ended=1",
                  stalls, seen, TO + 1);
      end
      set_idle();
      for (int c = 0; c < 3; c++) begin
         mem_done  = (c == 1);
         mem_err   = (c == 1);
         mem_rdata = 16'h7777;
         #2;
         n_cmp++;
         if (ctl !== 4'b0000 || readFromMem !== exp_rdata) begin
            n_bad++;
            $display("FAIL late_done c%0d: ctl=%b rfm=%h, expected ctl=0000 rfm=%h",
                     c, ctl, readFromMem, exp_rdata);
         end
         tick();
      end
   endtask

   task automatic test_halt_reset();
      set_idle();
      HALT_XM    = 1'b1;
      memRead_XM = 1'b1;
      addr_XM    = 16'h0020;
      mem_done   = 1'b1;
      mem_rdata  = 16'h4321;
      #2;
      n_cmp++;
      if (ctl !== 4'b0000 || readFromMem !== exp_rdata) begin
         n_bad++;
         $display("FAIL halt: ctl=%b rfm=%h, expected ctl=0000 rfm=%h", ctl, readFromMem, exp_rdata);
      end
      tick();
      set_idle();
      memRead_XM = 1'b1;
      addr_XM    = 16'h0030;
      #2;
      n_cmp++;
      if (ctl !== 4'b1100) begin
         n_bad++;
         $display("FAIL rst_wait_issue: ctl=%b, expected 1100", ctl);
      end
      tick();
      #2;
      n_cmp++;
      if (ctl !== 4'b0100) begin
         n_bad++;
         $display("FAIL rst_wait_w1: ctl=%b, expected 0100", ctl);
      end
      tick();
      rst = 1'b0;
      #1;
      exp_rdata = '0;
      n_cmp++;
      if (ctl !== 4'b0000 || readFromMem !== 16'h0000) begin
         n_bad++;
         $display("FAIL rst_wait_async: ctl=%b rfm=%h, expected ctl=0000 rfm=0000", ctl, readFromMem);
      end
      tick();
      set_idle();
      rst = 1'b1;
      tick();
      memRead_XM = 1'b1;
      addr_XM    = 16'h0040;
      mem_done   = 1'b1;
      mem_rdata  = 16'hA5A4;
      #2;
      n_cmp++;
      if (ctl !== 4'b1010 || readFromMem !== 16'hA5A4) begin
         n_bad++;
         $display("FAIL rst_wait_after: ctl=%b rfm=%h, expected ctl=1010 rfm=a5a4", ctl, readFromMem);
      end
      exp_rdata = 16'hA5A4;
      tick();
   endtask

   task automatic test_random();
      int            kind;
      int            dsel;
      int            d;
      int            ncyc;
      bit            rd;
      bit            legal;
      bit            ill;
      bit            dn;
      logic [3:0]    exp_ctl;
      logic [DW-1:0] a;
      logic [DW-1:0] wd;
      logic [DW-1:0] rdv;
      logic [DW-1:0] exp_rfm;
      for (int t = 0; t < 60; t++) begin
         set_idle();
         kind  = $urandom_range(0, 4);
         rd    = 1'b0;
         legal = 1'b0;
         ill   = 1'b0;
         a     = 16'($urandom) & 16'hFFFE;
         wd    = 16'($urandom);
         case (kind)
            1: begin
               HALT_XM     = 1'b1;
               memRead_XM  = 1'b1;
               memWrite_XM = 1'($urandom_range(0, 1));
               a[0]        = 1'($urandom_range(0, 1));
            end
            2: begin
               ill = 1'b1;
               if ($urandom_range(0, 1) == 1) begin
                  memRead_XM  = 1'b1;
                  memWrite_XM = 1'b1;
               end else begin
                  memRead_XM  = 1'($urandom_range(0, 1));
                  memWrite_XM = ~memRead_XM;
                  a[0]        = 1'b1;
               end
            end
            3: begin
               legal      = 1'b1;
               rd         = 1'b1;
               memRead_XM = 1'b1;
            end
            4: begin
               legal       = 1'b1;
               memWrite_XM = 1'b1;
            end
            default: ;
         endcase
         addr_XM  = a;
         wdata_XM = wd;
         dsel = $urandom_range(0, 9);
         if (dsel < 4)       d = 0;
         else if (dsel < 8)  d = $urandom_range(1, 5);
         else if (dsel == 8) d = TO + 1;
         else                d = -1;
         ncyc = legal ? ((d < 0) ? TO + 2 : d + 1) : 1;
         for (int c = 0; c < ncyc; c++) begin
            dn = legal ? (d >= 0 && c == d) : 1'($urandom_range(0, 1));
            mem_done  = dn;
            mem_err   = 1'($urandom_range(0, 1));
            rdv       = 16'($urandom);
            mem_rdata = rdv;
            exp_ctl[3] = legal && c == 0;
            exp_ctl[2] = legal && ((d < 0 && c <= TO) || (d >= 0 && c < d));
            exp_ctl[1] = legal && rd && dn;
            exp_ctl[0] = ill || (legal && dn && mem_err) || (legal && d < 0 && c == TO + 1);
            exp_rfm    = exp_ctl[1] ? rdv : exp_rdata;
            #2;
            n_cmp++;
            if (ctl !== exp_ctl || readFromMem !== exp_rfm) begin
               n_bad++;
               $display("FAIL rand t%0d k%0d d%0d c%0d: ctl=%b rfm=%h, expected ctl=%b rfm=%h",
                        t, kind, d, c, ctl, readFromMem, exp_ctl, exp_rfm);
            end
            if (exp_ctl[3]) begin
               n_cmp++;
               if (mem_wr !== ~rd || mem_addr !== a || mem_wdata !== wd) begin
                  n_bad++;
                  $display("FAIL rand_req t%0d: wr=%b addr=%h wdata=%h, expected wr=%b addr=%h wdata=%h",
                           t, mem_wr, mem_addr, mem_wdata, ~rd, a, wd);
               end
            end
            if (exp_ctl[1]) exp_rdata = rdv;
            tick();
         end
      end
   endtask

   initial begin
      test_reset();
      test_hit_load();
      test_miss_store();
      test_illegal();
      test_timeout();
      test_halt_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
